spi_mcu_master: RTL and testbench

SPI_MCU_MASTER -- requirements
Module: spi_mcu_master

---
 rtl/spi_mcu_master.sv | 198 +++++++++++++++++++
 tb/tb_spi_mcu_master.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_mcu_master.sv
// spi_mcu_master: serial link master towards an NDN router.
// TX side sends interest frames on mosi/cs; RX side receives data frames on miso.
// Both directions run independently, one link bit per clk cycle.
// Optional macro SPI_MCU_MASTER_FRAMECHK_EN: reject received frames whose end bit
// is 1 or whose header bit6 is set; without it every complete frame is accepted.
module spi_mcu_master #(
    parameter int PREFIX_BITS = 64,
    parameter int DATA_BITS   = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tx_valid,
    input  logic [5:0]             tx_length,
    input  logic [PREFIX_BITS-1:0] tx_prefix,
    output logic                   tx_ready,
    output logic                   tx_done,
    output logic                   mosi,
    output logic                   cs,
    input  logic                   miso,
    output logic                   rx_valid,
    output logic [7:0]             rx_header,
    output logic [DATA_BITS-1:0]   rx_data,
    output logic                   rx_error,
    output logic                   rx_busy
);

    localparam int MAX_BITS = (PREFIX_BITS > DATA_BITS) ? PREFIX_BITS : DATA_BITS;
    localparam int CNT_W    = $clog2(MAX_BITS + 1);
    localparam int TX_SH_W  = PREFIX_BITS + 8;

    localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(7);
    localparam logic [CNT_W-1:0] PFX_LAST = CNT_W'(PREFIX_BITS - 1);
    localparam logic [CNT_W-1:0] DAT_LAST = CNT_W'(DATA_BITS - 1);

    // ------------------------------------------------------------------
    // Transmit side
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_HEADER,
        TX_PREFIX,
        TX_END
    } tx_state_t;

    tx_state_t          tx_state;
    tx_state_t          tx_next;
    logic [CNT_W-1:0]   tx_cnt;
    logic [TX_SH_W-1:0] tx_shift;
    logic               tx_accept;

    // Ready is masked by reset so it reads low while rst is held.
    assign tx_ready  = (tx_state == TX_IDLE) && rst;
    assign tx_accept = tx_valid && tx_ready;
    assign cs        = (tx_state == TX_IDLE);

    // TX state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) tx_state <= TX_IDLE;
        else      tx_state <= tx_next;
    end

    // TX next-state decode
    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            TX_IDLE:   if (tx_accept) tx_next = TX_START;
            TX_START:  tx_next = TX_HEADER;
            TX_HEADER: if (tx_cnt == HDR_LAST) tx_next = TX_PREFIX;
            TX_PREFIX: if (tx_cnt == PFX_LAST) tx_next = TX_END;
            TX_END:    tx_next = TX_IDLE;
            default:   tx_next = TX_IDLE;
        endcase
    end

    // TX line driver: idle high, framing bits low, payload from shifter MSB
    always_comb begin
        mosi = 1'b1;
        case (tx_state)
            TX_START:  mosi = 1'b0;
            TX_HEADER: mosi = tx_shift[TX_SH_W-1];
            TX_PREFIX: mosi = tx_shift[TX_SH_W-1];
            TX_END:    mosi = 1'b0;
            default:   mosi = 1'b1;
        endcase
    end

    // TX datapath: latch header+prefix on acceptance, shift out, pulse done after end bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_cnt   <= '0;
            tx_shift <= '0;
            tx_done  <= 1'b0;
        end else begin
            tx_done <= (tx_state == TX_END);
            case (tx_state)
                TX_IDLE: begin
                    tx_cnt <= '0;
                    if (tx_accept) tx_shift <= {2'b01, tx_length, tx_prefix};
                end
                TX_HEADER: begin
                    tx_shift <= {tx_shift[TX_SH_W-2:0], 1'b0};
                    tx_cnt   <= (tx_cnt == HDR_LAST) ? '0 : tx_cnt + 1'b1;
                end
                TX_PREFIX: begin
                    tx_shift <= {tx_shift[TX_SH_W-2:0], 1'b0};
                    tx_cnt   <= (tx_cnt == PFX_LAST) ? tx_cnt : tx_cnt + 1'b1;
                end
                default: tx_cnt <= '0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Receive side
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        RX_IDLE,
        RX_HEADER,
        RX_DATA,
        RX_END
    } rx_state_t;

    rx_state_t            rx_state;
    rx_state_t            rx_next;
    logic [CNT_W-1:0]     rx_cnt;
    logic [7:0]           hdr_shift;
    logic [DATA_BITS-1:0] data_shift;
    logic                 frame_ok;

    assign rx_busy = (rx_state != RX_IDLE);

`ifdef SPI_MCU_MASTER_FRAMECHK_EN
    // At the end-bit sample: end bit must be 0 and header must not flag an interest.
    assign frame_ok = (miso == 1'b0) && (hdr_shift[6] == 1'b0);

    // Reject pulse, one cycle after a failing end-bit sample
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rx_error <= 1'b0;
        else      rx_error <= (rx_state == RX_END) && !frame_ok;
    end
`else
    assign frame_ok = 1'b1;
    assign rx_error = 1'b0;
`endif

    // RX state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rx_state <= RX_IDLE;
        else      rx_state <= rx_next;
    end

    // RX next-state decode; a low miso in idle is the start bit
    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:   if (miso == 1'b0) rx_next = RX_HEADER;
            RX_HEADER: if (rx_cnt == HDR_LAST) rx_next = RX_DATA;
            RX_DATA:   if (rx_cnt == DAT_LAST) rx_next = RX_END;
            RX_END:    rx_next = RX_IDLE;
            default:   rx_next = RX_IDLE;
        endcase
    end

    // RX datapath: shift header and payload in, publish on a good end bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_cnt     <= '0;
            hdr_shift  <= '0;
            data_shift <= '0;
            rx_header  <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (rx_state)
                RX_HEADER: begin
                    hdr_shift <= {hdr_shift[6:0], miso};
                    rx_cnt    <= (rx_cnt == HDR_LAST) ? '0 : rx_cnt + 1'b1;
                end
                RX_DATA: begin
                    data_shift <= {data_shift[DATA_BITS-2:0], miso};
                    rx_cnt     <= (rx_cnt == DAT_LAST) ? rx_cnt : rx_cnt + 1'b1;
                end
                RX_END: begin
                    rx_cnt <= '0;
                    if (frame_ok) begin
                        rx_header <= hdr_shift;
                        rx_data   <= data_shift;
                        rx_valid  <= 1'b1;
                    end
                end
                default: rx_cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_mcu_master.sv
// Self-checking bench for spi_mcu_master: scoreboarded TX bit stream and RX frames.
module tb_spi_mcu_master;

    localparam int PB = 64;
    localparam int DB = 256;
    localparam logic [DB-1:0] PAY = {4{64'h0123_4567_89AB_CDEF}};
`ifdef SPI_MCU_MASTER_FRAMECHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          tx_valid;
    logic [5:0]    tx_length;
    logic [PB-1:0] tx_prefix;
    logic          tx_ready;
    logic          tx_done;
    logic          mosi;
    logic          cs;
    logic          miso;
    logic          rx_valid;
    logic [7:0]    rx_header;
    logic [DB-1:0] rx_data;
    logic          rx_error;
    logic          rx_busy;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic b;
        logic last;
    } tx_exp_t;

    typedef struct packed {
        logic          ok;
        logic [7:0]    hdr;
        logic [DB-1:0] data;
    } rx_exp_t;

    tx_exp_t       tx_q[$];
    rx_exp_t       rx_q[$];
    logic          exp_done  = 1'b0;
    logic [7:0]    last_hdr  = '0;
    logic [DB-1:0] last_data = '0;

    spi_mcu_master #(
        .PREFIX_BITS(PB),
        .DATA_BITS  (DB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_valid (tx_valid),
        .tx_length(tx_length),
        .tx_prefix(tx_prefix),
        .tx_ready (tx_ready),
        .tx_done  (tx_done),
        .mosi     (mosi),
        .cs       (cs),
        .miso     (miso),
        .rx_valid (rx_valid),
        .rx_header(rx_header),
        .rx_data  (rx_data),
        .rx_error (rx_error),
        .rx_busy  (rx_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DB-1:0] obs, input logic [DB-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void push_tx(input logic [5:0] len, input logic [PB-1:0] pfx);
        tx_exp_t    e;
        logic [7:0] hdr;
        hdr    = {2'b01, len};
        e.b    = 1'b0;
        e.last = 1'b0;
        tx_q.push_back(e);
        for (int i = 7; i >= 0; i--) begin
            e.b = hdr[i];
            tx_q.push_back(e);
        end
        for (int i = PB - 1; i >= 0; i--) begin
            e.b = pfx[i];
            tx_q.push_back(e);
        end
        e.b    = 1'b0;
        e.last = 1'b1;
        tx_q.push_back(e);
    endfunction

    function automatic logic rx_ok(input logic [7:0] hdr, input logic endb);
        return !CHK || (!endb && !hdr[6]);
    endfunction

    function automatic void push_rx(input logic ok, input logic [7:0] hdr, input logic [DB-1:0] data);
        rx_exp_t e;
        e.ok   = ok;
        e.hdr  = hdr;
        e.data = data;
        rx_q.push_back(e);
        if (ok) begin
            last_hdr  = hdr;
            last_data = data;
        end
    endfunction

    task automatic send_tx(input logic [5:0] len, input logic [PB-1:0] pfx, output logic done_at_accept);
        tx_valid  = 1'b1;
        tx_length = len;
        tx_prefix = pfx;
        for (int i = 0; i < 300 && tx_ready !== 1'b1; i++) begin
            @(posedge clk); #1;
        end
        check("tx_ready_accept", tx_ready, 1);
        done_at_accept = tx_done;
        push_tx(len, pfx);
        @(posedge clk); #1;
        tx_valid  = 1'b0;
        tx_length = ~len;
        tx_prefix = ~pfx;
    endtask

    task automatic wait_tx_done(output int cycles);
        cycles = 0;
        while (tx_done !== 1'b1 && cycles < 200) begin
            @(posedge clk); #1;
            cycles++;
        end
        check("tx_done_seen", tx_done, 1);
    endtask

    task automatic send_rx(input logic [7:0] hdr, input logic [DB-1:0] data, input logic endb);
        miso = 1'b0;
        @(posedge clk); #1;
        for (int i = 7; i >= 0; i--) begin
            miso = hdr[i];
            @(posedge clk); #1;
        end
        for (int i = DB - 1; i >= 0; i--) begin
            miso = data[i];
            @(posedge clk); #1;
        end
        miso = endb;
        @(posedge clk); #1;
        miso = 1'b1;
    endtask

    task automatic check_rx_hold();
        repeat (3) @(posedge clk);
        #1;
        check("rx_header_hold", rx_header, last_hdr);
        check("rx_data_hold", rx_data, last_data);
        check("rx_busy_idle", rx_busy, 0);
    endtask

    // Scoreboard monitor, sampled on the falling edge
    always @(negedge clk) begin
        tx_exp_t te;
        rx_exp_t re;
        check("tx_done", tx_done, exp_done);
        exp_done = 1'b0;
        if (cs === 1'b0) begin
            check("cs_low_expected", tx_q.size() != 0, 1);
            if (tx_q.size() != 0) begin
                te = tx_q.pop_front();
                check("mosi", mosi, te.b);
                exp_done = te.last;
            end
        end
        if (rx_valid === 1'b1 || rx_error === 1'b1) begin
            check("rx_pulse_expected", rx_q.size() != 0, 1);
            if (rx_q.size() != 0) begin
                re = rx_q.pop_front();
                check("rx_valid", rx_valid, re.ok);
                check("rx_error", rx_error, !re.ok);
                if (re.ok) begin
                    check("rx_header", rx_header, re.hdr);
                    check("rx_data", rx_data, re.data);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic          d;
        int            c;
        int            low;
        logic [DB-1:0] pay2;
        logic [DB-1:0] pay3;
        logic [DB-1:0] pay4;

        rst       = 1'b0;
        tx_valid  = 1'b0;
        tx_length = '0;
        tx_prefix = '0;
        miso      = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mosi", mosi, 1);
        check("rst_cs", cs, 1);
        check("rst_tx_ready", tx_ready, 0);
        check("rst_tx_done", tx_done, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_error", rx_error, 0);
        check("rst_rx_busy", rx_busy, 0);
        check("rst_rx_header", rx_header, 0);
        check("rst_rx_data", rx_data, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("tx_ready_after_rst", tx_ready, 1);

        // Single interest frame: length and timing
        send_tx(6'h2A, 64'hDEADBEEF01234567, d);
        c   = 1;
        low = (cs === 1'b0) ? 1 : 0;
        while (tx_done !== 1'b1 && c < 200) begin
            @(posedge clk); #1;
            c++;
            if (cs === 1'b0) low++;
        end
        check("tx_done_cycle", c, 75);
        check("cs_low_cycles", low, 74);
        repeat (2) @(posedge clk);
        #1;

        // Back-to-back interests with the second request held while busy
        send_tx(6'h15, 64'h0123_4567_89AB_CDEF, d);
        send_tx(6'h3F, 64'hF0E1_D2C3_B4A5_9687, d);
        check("b2b_done_at_accept", d, 1);
        check("b2b_start_cs", cs, 0);
        check("b2b_start_mosi", mosi, 0);
        wait_tx_done(c);
        check("b2b_second_len", c, 74);

        // Good data frame
        push_rx(rx_ok(8'h00, 1'b0), 8'h00, PAY);
        send_rx(8'h00, PAY, 1'b0);
        check_rx_hold();

        // End bit 1 with a new payload
        pay2 = ~PAY;
        push_rx(rx_ok(8'h00, 1'b1), 8'h00, pay2);
        send_rx(8'h00, pay2, 1'b1);
        check_rx_hold();

        // Interest header on the receive side
        for (int i = 0; i < DB / 32; i++) pay3[i*32 +: 32] = $urandom;
        push_rx(rx_ok(8'h40, 1'b0), 8'h40, pay3);
        send_rx(8'h40, pay3, 1'b0);
        check_rx_hold();

        // Back-to-back receive frames
        for (int i = 0; i < DB / 32; i++) pay4[i*32 +: 32] = $urandom;
        push_rx(rx_ok(8'hA5, 1'b0), 8'hA5, pay4);
        push_rx(rx_ok(8'h3C, 1'b0), 8'h3C, pay3);
        send_rx(8'hA5, pay4, 1'b0);
        send_rx(8'h3C, pay3, 1'b0);
        check_rx_hold();

        // Reset in the middle of a TX and an RX frame
        fork
            begin
                miso = 1'b0;
                @(posedge clk); #1;
                for (int i = 0; i < 100; i++) begin
                    miso = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
            end
            begin
                repeat (70) @(posedge clk);
                #1;
                send_tx(6'h11, 64'hA5A5_5A5A_0F0F_F0F0, d);
                repeat (29) @(posedge clk);
                #1;
            end
        join
        check("pre_rst_rx_busy", rx_busy, 1);
        check("pre_rst_cs", cs, 0);
        tx_q.delete();
        rst  = 1'b0;
        miso = 1'b1;
        #1;
        check("abort_mosi", mosi, 1);
        check("abort_cs", cs, 1);
        check("abort_rx_busy", rx_busy, 0);
        check("abort_tx_ready", tx_ready, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Full-duplex recovery after the abort
        fork
            begin
                int cc;
                logic dd;
                send_tx(6'h07, 64'h1111_2222_3333_4444, dd);
                wait_tx_done(cc);
                check("post_rst_tx_len", cc, 74);
            end
            begin
                push_rx(rx_ok(8'h2B, 1'b0), 8'h2B, pay4);
                send_rx(8'h2B, pay4, 1'b0);
            end
        join
        check_rx_hold();

        repeat (3) @(posedge clk);
        #1;
        check("tx_q_drained", tx_q.size(), 0);
        check("rx_q_drained", rx_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
